// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: instruction fetch stage with IF/ID register.
// Issues word-aligned reads, buffers one word under stall, drops stale reads.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   imem_req/addr     read request and word address to instruction memory
//   imem_ack/rdata    read completion and returned instruction word
//   redirect/_pc      new PC from decode (low two bits ignored)
//   stall             ID cannot take a new IF/ID entry
//   if_valid/ins/pc   IF/ID entry
//   if_pc_4           if_pc + 4
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        if_valid,
  output logic [31:0] if_ins,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_4
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [31:0] pc, pc_nx;
  logic [31:0] drop_addr, drop_addr_nx;
  logic [31:0] hold_ins, hold_ins_nx;
  logic [31:0] hold_pc, hold_pc_nx;
  logic        if_valid_nx;
  logic [31:0] if_ins_nx;
  logic [31:0] if_pc_nx;
  logic [31:0] if_pc_4_nx;

  logic [31:0] pc_inc;
  logic [31:0] hold_inc;
  logic [31:0] tgt;
  logic        slot_free;

  assign pc_inc    = pc + 32'd4;
  assign hold_inc  = hold_pc + 32'd4;
  assign tgt       = {redirect_pc[31:2], 2'b00};
  assign slot_free = !if_valid || !stall;

  // DROP keeps presenting the abandoned address so the
  // in-flight read can complete and be thrown away.
  assign imem_req  = (state != HOLD);
  assign imem_addr = (state == DROP) ? drop_addr : pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      drop_addr <= '0;
      hold_ins  <= '0;
      hold_pc   <= '0;
      if_valid  <= 1'b0;
      if_ins    <= '0;
      if_pc     <= '0;
      if_pc_4   <= '0;
    end else begin
      state     <= state_nx;
      pc        <= pc_nx;
      drop_addr <= drop_addr_nx;
      hold_ins  <= hold_ins_nx;
      hold_pc   <= hold_pc_nx;
      if_valid  <= if_valid_nx;
      if_ins    <= if_ins_nx;
      if_pc     <= if_pc_nx;
      if_pc_4   <= if_pc_4_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    pc_nx        = pc;
    drop_addr_nx = drop_addr;
    hold_ins_nx  = hold_ins;
    hold_pc_nx   = hold_pc;
    if_valid_nx  = if_valid;
    if_ins_nx    = if_ins;
    if_pc_nx     = if_pc;
    if_pc_4_nx   = if_pc_4;

    unique case (state)
      FETCH: begin
        if (redirect) begin
          pc_nx       = tgt;
          if_valid_nx = 1'b0;
          if (!imem_ack) begin
            drop_addr_nx = pc;
            state_nx     = DROP;
          end
        end else if (imem_ack) begin
          pc_nx = pc_inc;
          if (slot_free) begin
            if_valid_nx = 1'b1;
            if_ins_nx   = imem_rdata;
            if_pc_nx    = pc;
            if_pc_4_nx  = pc_inc;
          end else begin
            hold_ins_nx = imem_rdata;
            hold_pc_nx  = pc;
            state_nx    = HOLD;
          end
        end else if (!stall) begin
          if_valid_nx = 1'b0;
        end
      end

      HOLD: begin
        if (redirect) begin
          pc_nx       = tgt;
          if_valid_nx = 1'b0;
          state_nx    = FETCH;
        end else if (!stall) begin
          if_valid_nx = 1'b1;
          if_ins_nx   = hold_ins;
          if_pc_nx    = hold_pc;
          if_pc_4_nx  = hold_inc;
          state_nx    = FETCH;
        end
      end

      DROP: begin
        if (redirect) begin
          pc_nx       = tgt;
          if_valid_nx = 1'b0;
        end else if (imem_ack) begin
          state_nx = FETCH;
        end
      end

      default: begin
        state_nx    = FETCH;
        if_valid_nx = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: random bench for pc_fetch_unit.
// Queue-based fetch model, random memory latency, stall and redirect.
module tb_pc_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        stall = 1'b0;
  logic        if_valid;
  logic [31:0] if_ins;
  logic [31:0] if_pc;
  logic [31:0] if_pc_4;

  pc_fetch_unit #(.RESET_PC(RPC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .stall      (stall),
    .if_valid   (if_valid),
    .if_ins     (if_ins),
    .if_pc      (if_pc),
    .if_pc_4    (if_pc_4)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h t=%0t",
               tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] insn(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
  } ent_t;

  // Model: next fetch address, an optional stale read that
  // must be swallowed, a queue of fetched words ID has not
  // taken yet, and the presented IF/ID entry.
  logic [31:0] m_pc;
  bit          m_stale;
  logic [31:0] m_stale_addr;
  ent_t        buf_q[$];
  bit          m_ov;
  logic [31:0] m_oins;
  logic [31:0] m_opc;
  int          mem_cnt;
  logic [31:0] tgt;

  task automatic model_reset();
    m_pc         = RPC;
    m_stale      = 0;
    m_stale_addr = '0;
    buf_q.delete();
    m_ov         = 0;
    m_oins       = '0;
    m_opc        = '0;
    mem_cnt      = -1;
  endtask

  // Called at a falling edge: check outputs, drive inputs for
  // the next rising edge, advance the model, wait one cycle.
  task automatic cycle(input bit st, input bit rd,
                       input logic [31:0] rpc,
                       input int lat_max);
    logic [31:0] ea;
    bit ereq;
    bit ack;
    bit free;
    ent_t e;
    ereq = (buf_q.size() == 0);
    ea   = m_stale ? m_stale_addr : m_pc;
    check("imem_req", imem_req, ereq);
    if (ereq) check("imem_addr", imem_addr, ea);
    check("if_valid", if_valid, m_ov);
    if (m_ov) begin
      check("if_ins", if_ins, m_oins);
      check("if_pc", if_pc, m_opc);
      check("if_pc_4", if_pc_4, m_opc + 32'd4);
    end

    ack = 0;
    if (ereq) begin
      if (mem_cnt < 0) mem_cnt = $urandom_range(lat_max, 0);
      if (mem_cnt == 0) begin
        ack     = 1;
        mem_cnt = -1;
      end else begin
        mem_cnt--;
      end
    end
    imem_ack    = ack;
    imem_rdata  = ack ? insn(ea) : $urandom;
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;

    free = !m_ov || !st;
    if (rd) begin
      if (!m_stale && buf_q.size() == 0 && !ack) begin
        m_stale      = 1;
        m_stale_addr = m_pc;
      end
      buf_q.delete();
      m_pc = {rpc[31:2], 2'b00};
      m_ov = 0;
    end else if (m_stale) begin
      if (ack) m_stale = 0;
    end else if (buf_q.size() != 0) begin
      if (!st) begin
        e      = buf_q.pop_front();
        m_ov   = 1;
        m_oins = e.ins;
        m_opc  = e.pc;
      end
    end else if (ack) begin
      e.ins = insn(ea);
      e.pc  = m_pc;
      m_pc  = m_pc + 32'd4;
      if (free) begin
        m_ov   = 1;
        m_oins = e.ins;
        m_opc  = e.pc;
      end else begin
        buf_q.push_back(e);
      end
    end else if (!st) begin
      m_ov = 0;
    end
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_valid", if_valid, 0);
    check("rst_ins", if_ins, 0);
    check("rst_pc", if_pc, 0);
    check("rst_pc_4", if_pc_4, 0);
    check("rst_req", imem_req, 1);
    check("rst_addr", imem_addr, RPC);
    rst_n = 1'b1;

    repeat (12) cycle(0, 0, '0, 0);

    repeat (3) cycle(1, 0, '0, 0);
    repeat (4) cycle(0, 0, '0, 0);

    cycle(0, 0, '0, 3);
    cycle(0, 1, 32'h0040_0102, 3);
    repeat (8) cycle(0, 0, '0, 3);

    cycle(0, 1, 32'h0000_0010, 0);
    cycle(0, 1, 32'h0040_0102, 0);
    repeat (3) cycle(0, 0, '0, 0);

    cycle(0, 1, 32'hFFFF_FFF4, 0);
    repeat (5) cycle(0, 0, '0, 0);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(1, 0) == 1) tgt = $urandom;
      else tgt = 32'hFFFF_FFF0 + $urandom_range(15, 0);
      cycle($urandom_range(99, 0) < 30,
            $urandom_range(99, 0) < 8,
            tgt, $urandom_range(3, 0));
    end

    repeat (3) cycle(0, 0, '0, 0);
    repeat (4) cycle(1, 0, '0, 0);
    imem_ack = 1'b0;
    redirect = 1'b0;
    stall    = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("arst_valid", if_valid, 0);
    check("arst_req", imem_req, 1);
    check("arst_addr", imem_addr, RPC);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (6) cycle(0, 0, '0, 0);

    for (int i = 0; i < 500; i++) begin
      cycle($urandom_range(99, 0) < 40,
            $urandom_range(99, 0) < 10,
            $urandom, $urandom_range(2, 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
